mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port data `ram` between the CPU's instruction-fetch path and its load/store path, so a single memory image can serve both. The block sits between `cpu` and `ram`. It arbitrates one access per cycle with data-side priority and a bounded anti-starvation guard for fetch. It returns registered read data with a one-cycle response strobe per requester.

## Interface

**Parameters**
- `STARVE_LIMIT`, default 3: consecutive denied fetch cycles after which fetch wins unconditionally. Legal range 1..15.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `inst_req`  in  1  fetch request.
- `inst_addr`  in  32  fetch byte address.
- `inst_ready`  out  1  fetch accepted this cycle (combinational).
- `inst_rvalid`  out  1  `inst_rdata` valid (registered).
- `inst_rdata`  out  32  fetched word.
- `data_req`  in  1  load/store request.
- `data_addr`  in  32  load/store byte address.
- `data_we`  in  1  1 = store.
- `data_wdata`  in  32  store data.
- `data_mask`  in  `memory_mask_t`  byte-lane mask.
- `data_ready`  out  1  data access accepted this cycle (combinational).
- `data_rvalid`  out  1  data response valid (registered); pulses for loads and stores.
- `data_rdata`  out  32  load data; 0 on store acks.
- `memory_address`  out  32  to `ram.a`.
- `memory_write`  out  32  to `ram.wd`.
- `memory_mask`  out  `memory_mask_t`  to `ram.mask`.
- `memory_we`  out  1  to `ram.we`.
- `memory_out`  in  32  from `ram.rd`; combinational read.

## Operation

**Grant rule (combinational, per cycle)**
- With `rst_n`=0, there is no grant.
- Only one requester asserting: that requester wins.
- Both requesting: data wins, unless `starve_cnt` ≥ `STARVE_LIMIT`, in which case fetch wins.
- `inst_ready` and `data_ready` are one-hot or zero, and are never asserted without the matching `req`.

**Memory drive**
- Fetch granted: `memory_address`=`inst_addr`, `memory_mask`=word mask, `memory_we`=0.
- Data granted: `memory_address`=`data_addr`, `memory_mask`=`data_mask`, `memory_write`=`data_wdata`, `memory_we`=`data_we`.
- No grant: `memory_we`=0. Address, mask and write data hold the data-side inputs.

**Response FSM (registered owner of the previous cycle)**
- States: IDLE, INST, DATA.
- The next state is the winner of the current cycle, or IDLE if there is no winner.
- INST: `inst_rvalid`=1, and `inst_rdata` holds the `memory_out` value captured at the grant edge.
- DATA: `data_rvalid`=1. `data_rdata` holds the captured `memory_out` for a load, or 0 for a store.
- Rdata registers hold their value until the next response of the same requester.

**Starvation counter `starve_cnt` (4 bits)**
- Increments, saturating at 15, in each cycle where `inst_req`=1 and `inst_ready`=0.
- Clears in each cycle where fetch is granted or `inst_req`=0.

**Reset**
- Synchronous, active-low; applies at any point, including with a response pending.
- State returns to IDLE and `starve_cnt`=0.
- Both rvalids are 0 and both rdata registers are 0.
- A pending response is dropped and is not replayed.
- `memory_we`=0 throughout reset.

## Timing

- Acceptance latency is 0 cycles: `*_ready` is valid in the same cycle as `*_req`.
- Read data appears exactly 1 cycle after acceptance, with `*_rvalid` high for exactly one cycle per accepted access.
- Back-to-back grants to the same requester give back-to-back rvalid pulses, for full throughput of 1 access per cycle.
- A store is committed by `ram` at the grant edge, so a load granted in the next cycle reads the new data.
- A requester must hold its request and payload stable until `*_ready` is seen. The arbiter neither registers nor queues denied requests.
- Worst-case fetch wait under continuous data traffic is `STARVE_LIMIT` cycles; fetch is granted on the following cycle.

## Test plan

1. **Reset.** Hold `rst_n`=0 for 2 cycles with both requests high → every output is 0, including `memory_we`. Release reset → the first grant goes to data.
2. **Lone fetch.** RAM word at 0x10 = 0xDEADBEEF; `inst_req`=1, `inst_addr`=0x10 → `inst_ready`=1 in the same cycle. One cycle later, `inst_rvalid`=1 and `inst_rdata`=0xDEADBEEF; `data_rvalid` stays 0.
3. **Store then load.** Store 0x12345678 to 0x20 with a full mask, then load 0x20 in the next cycle → the store ack has `data_rdata`=0, and the load response is 0x12345678. `memory_we` is high only in the store cycle.
4. **Contention and starvation.** Hold both requests continuously with `STARVE_LIMIT`=3 → the grant sequence is D,D,D,I,D,D,D,I…. Each fetch rvalid arrives one cycle after its grant.
5. **Reset mid-access.** Grant a fetch, then assert `rst_n`=0 on the next edge → no `inst_rvalid` pulse is produced, and both rdata registers read 0.
6. **Byte store.** Store 0xAB to 0x31 with a byte mask → `memory_mask` equals `data_mask`. A later word load of 0x30 returns only byte lane 1 changed.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Data side has priority; a saturating counter forces a fetch grant after STARVE_LIMIT denials.
package mem_port_arbiter_pkg;
    typedef logic [3:0] memory_mask_t;
    localparam memory_mask_t WORD_MASK = 4'hF;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_req,
    input  logic [31:0]        inst_addr,
    output logic               inst_ready,
    output logic               inst_rvalid,
    output logic [31:0]        inst_rdata,
    input  logic               data_req,
    input  logic [31:0]        data_addr,
    input  logic               data_we,
    input  logic [31:0]        data_wdata,
    input  memory_mask_t       data_mask,
    output logic               data_ready,
    output logic               data_rvalid,
    output logic [31:0]        data_rdata,
    output logic [31:0]        memory_address,
    output logic [31:0]        memory_write,
    output memory_mask_t       memory_mask,
    output logic               memory_we,
    input  logic [31:0]        memory_out
);
    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] inst_rdata_q, data_rdata_q;
    logic        fetch_forced, inst_gnt, data_gnt;

    // The two grant terms are mutually exclusive by construction.
    always_comb begin
        fetch_forced = (starve_q >= LIMIT);
        inst_gnt     = rst_n && inst_req && (!data_req || fetch_forced);
        data_gnt     = rst_n && data_req && !(inst_req && fetch_forced);
    end

    always_comb begin
        memory_address = data_addr;
        memory_write   = data_wdata;
        memory_mask    = data_mask;
        memory_we      = 1'b0;
        if (inst_gnt) begin
            memory_address = inst_addr;
            memory_mask    = WORD_MASK;
        end else if (data_gnt) begin
            memory_we = data_we;
        end
    end

    always_comb begin
        starve_d = '0;
        if (inst_req && !inst_gnt)
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (inst_gnt) begin
                state_q      <= INST;
                inst_rdata_q <= memory_out;
            end else if (data_gnt) begin
                state_q      <= DATA;
                data_rdata_q <= data_we ? '0 : memory_out;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign inst_ready  = inst_gnt;
    assign data_ready  = data_gnt;
    assign inst_rvalid = (state_q == INST);
    assign data_rvalid = (state_q == DATA);
    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a RAM, a transaction-level model and literal checks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inst_req, data_req, data_we;
    logic [31:0]  inst_addr, data_addr, data_wdata;
    memory_mask_t data_mask;
    logic         inst_ready, inst_rvalid, data_ready, data_rvalid, memory_we;
    logic [31:0]  inst_rdata, data_rdata, memory_address, memory_write, memory_out;
    memory_mask_t memory_mask;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_wdata(data_wdata), .data_mask(data_mask), .data_ready(data_ready),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .memory_address(memory_address), .memory_write(memory_write),
        .memory_mask(memory_mask), .memory_we(memory_we), .memory_out(memory_out)
    );

    // RAM environment: combinational read, masked write at the edge.
    logic [31:0] ram   [0:255];
    logic [31:0] m_mem [0:255];

    assign memory_out = ram[memory_address[9:2]];

    always @(posedge clk) begin
        if (memory_we)
            for (int b = 0; b < 4; b++)
                if (memory_mask[b]) ram[memory_address[9:2]][8*b +: 8] <= memory_write[8*b +: 8];
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: consecutive fetch denials and the expected response of last cycle.
    int          m_starve = 0;
    logic        m_irv = 1'b0, m_drv = 1'b0;
    logic [31:0] m_ird = '0, m_drd = '0;
    logic        g_i, g_d, c_i, c_d;

    function automatic logic data_wins();
        return rst_n && data_req && !(inst_req && m_starve >= LIMIT);
    endfunction

    always @(posedge clk) begin
        g_d = data_wins();
        g_i = rst_n && inst_req && !g_d;
        if (!rst_n) begin
            m_starve = 0;
            m_irv = 1'b0; m_drv = 1'b0;
            m_ird = '0;   m_drd = '0;
        end else begin
            m_irv = g_i;
            m_drv = g_d;
            if (g_i) m_ird = m_mem[inst_addr[9:2]];
            if (g_d) begin
                m_drd = data_we ? 32'h0 : m_mem[data_addr[9:2]];
                if (data_we) m_mem[data_addr[9:2]] = merge(m_mem[data_addr[9:2]], data_wdata, data_mask);
            end
            m_starve = (inst_req && !g_i) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
        end
    end

    always @(negedge clk) begin
        c_d = data_wins();
        c_i = rst_n && inst_req && !c_d;
        chk("inst_ready", inst_ready, c_i);
        chk("data_ready", data_ready, c_d);
        chk("memory_we", memory_we, c_d && data_we);
        chk("memory_address", memory_address, c_i ? inst_addr : data_addr);
        chk("memory_mask", memory_mask, c_i ? 4'hF : data_mask);
        if (!c_i) chk("memory_write", memory_write, data_wdata);
        chk("inst_rvalid", inst_rvalid, m_irv);
        chk("data_rvalid", data_rvalid, m_drv);
        chk("inst_rdata", inst_rdata, m_ird);
        chk("data_rdata", data_rdata, m_drd);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    logic [11:0] grants;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        ram[8'h04] = 32'hDEADBEEF; m_mem[8'h04] = 32'hDEADBEEF;
        ram[8'h0C] = 32'h11223344; m_mem[8'h0C] = 32'h11223344;

        rst_n = 1'b0; inst_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
        inst_addr = '0; data_addr = '0; data_wdata = '0; data_mask = '0;

        // Reset with both requests high
        at_neg();
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_memory_we", memory_we, 0);
        chk("rst_rvalids", {inst_rvalid, data_rvalid}, 0);
        chk("rst_rdatas", inst_rdata | data_rdata, 0);
        tick();
        rst_n = 1'b1;
        at_neg();
        chk("first_grant_data", {inst_ready, data_ready}, 2'b01);
        tick();
        inst_req = 1'b0; data_req = 1'b0;
        tick();

        // Lone fetch
        inst_req = 1'b1; inst_addr = 32'h10;
        at_neg();
        chk("fetch_ready", inst_ready, 1);
        tick();
        inst_req = 1'b0;
        at_neg();
        chk("fetch_rvalid", inst_rvalid, 1);
        chk("fetch_rdata", inst_rdata, 32'hDEADBEEF);
        chk("fetch_no_data_rvalid", data_rvalid, 0);
        tick();

        // Store then load
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'h12345678; data_mask = 4'hF;
        at_neg();
        chk("store_we", memory_we, 1);
        tick();
        data_we = 1'b0;
        at_neg();
        chk("store_ack_rvalid", data_rvalid, 1);
        chk("store_ack_rdata", data_rdata, 0);
        chk("load_we_low", memory_we, 0);
        tick();
        data_req = 1'b0;
        at_neg();
        chk("load_rvalid", data_rvalid, 1);
        chk("load_rdata", data_rdata, 32'h12345678);
        tick();

        // Contention: expect D,D,D,I repeating
        inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_addr = 32'h20;
        for (int i = 0; i < 12; i++) begin
            at_neg();
            grants[i] = inst_ready;
            if (i > 0) chk("contend_inst_rvalid", inst_rvalid, ((i - 1) % 4) == 3);
            tick();
        end
        chk("grant_sequence", grants, 12'h888);
        inst_req = 1'b0; data_req = 1'b0;
        tick();

        // Reset lands on the fetch grant edge
        inst_req = 1'b1; inst_addr = 32'h10;
        at_neg();
        chk("pre_reset_ready", inst_ready, 1);
        rst_n = 1'b0;
        tick();
        inst_req = 1'b0;
        at_neg();
        chk("reset_drop_rvalid", inst_rvalid, 0);
        chk("reset_inst_rdata", inst_rdata, 0);
        chk("reset_data_rdata", data_rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Byte store into lane 1 of word 0x30
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h31; data_wdata = 32'h0000AB00; data_mask = 4'b0010;
        at_neg();
        chk("byte_mask", memory_mask, 4'b0010);
        chk("byte_we", memory_we, 1);
        tick();
        data_we = 1'b0; data_addr = 32'h30; data_mask = 4'hF;
        tick();
        data_req = 1'b0;
        at_neg();
        chk("byte_load_rdata", data_rdata, 32'h1122AB44);
        tick();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
